// File: rtl/proc_control_fsm_if.sv
// rtl/proc_control_fsm_if.sv - control-unit signal bundle between the sequencer (master) and the datapath (slave)
interface proc_control_fsm_if;
  logic       Run;
  logic [8:0] DIN;
  logic       Gnz;
  logic [7:0] Rout;
  logic       Gout;
  logic       DINout;
  logic [7:0] Rin;
  logic       Ain;
  logic       Gin;
  logic       AddSub;
  logic       Done;

  modport master (
    input  Run, DIN, Gnz,
    output Rout, Gout, DINout, Rin, Ain, Gin, AddSub, Done
  );

  modport slave (
    output Run, DIN, Gnz,
    input  Rout, Gout, DINout, Rin, Ain, Gin, AddSub, Done
  );
endinterface

// File: rtl/proc_control_fsm.sv
// rtl/proc_control_fsm.sv - T0..T3 instruction sequencer for the 9-bit datapath; PROC_MVNZ_EN enables opcode 100 (mvnz)
module proc_control_fsm (
  input  logic                 Clock,
  input  logic                 Resetn,
  proc_control_fsm_if.master   bus
);

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  state_t     state;
  state_t     state_next;
  logic [8:0] ir;

  wire [2:0] opcode = ir[8:6];
  wire [2:0] rx     = ir[5:3];
  wire [2:0] ry     = ir[2:0];

  // Register i maps to bit 7-i, so R0 is the MSB.
  function automatic logic [7:0] reg_sel(input logic [2:0] idx);
    logic [7:0] onehot;
    onehot = 8'b1000_0000 >> idx;
    return onehot;
  endfunction

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= T0;
      ir    <= 9'd0;
    end else begin
      state <= state_next;
      if (state == T0 && bus.Run)
        ir <= bus.DIN;
    end
  end

  always_comb begin
    state_next  = state;
    bus.Rout    = 8'd0;
    bus.Gout    = 1'b0;
    bus.DINout  = 1'b0;
    bus.Rin     = 8'd0;
    bus.Ain     = 1'b0;
    bus.Gin     = 1'b0;
    bus.AddSub  = 1'b0;
    bus.Done    = 1'b0;

    case (state)
      T0: begin
        if (bus.Run)
          state_next = T1;
      end
      T1: begin
        state_next = T0;
        case (opcode)
          3'b000: begin
            bus.Rout = reg_sel(ry);
            bus.Rin  = reg_sel(rx);
            bus.Done = 1'b1;
          end
          3'b001: begin
            bus.DINout = 1'b1;
            bus.Rin    = reg_sel(rx);
            bus.Done   = 1'b1;
          end
          3'b010, 3'b011: begin
            bus.Rout   = reg_sel(rx);
            bus.Ain    = 1'b1;
            state_next = T2;
          end
`ifdef PROC_MVNZ_EN
          3'b100: begin
            // Conditional move: when G is zero the instruction retires with no write.
            if (bus.Gnz) begin
              bus.Rout = reg_sel(ry);
              bus.Rin  = reg_sel(rx);
            end
            bus.Done = 1'b1;
          end
`endif
          default: begin
            bus.Done = 1'b1;
          end
        endcase
      end
      T2: begin
        bus.Rout   = reg_sel(ry);
        bus.Gin    = 1'b1;
        bus.AddSub = ir[6];
        state_next = T3;
      end
      T3: begin
        bus.Gout   = 1'b1;
        bus.Rin    = reg_sel(rx);
        bus.Done   = 1'b1;
        state_next = T0;
      end
      default: state_next = T0;
    endcase
  end

endmodule

// File: doc/proc_control_fsm.md
# proc_control_fsm

Instruction-sequencing control unit for the 9-bit processor datapath. Fetches a 9-bit instruction from `DIN` into an internal instruction register, then steps a four-state FSM (T0–T3) that drives the bus-multiplexer selects (`Gout`, `DINout`, `Rout`), the register and ALU load enables, and `Done`. It sits beside the bus multiplexer and owns all of its select lines, so at most one bus source is ever selected.

## Interface
Parameters:
- none; the instruction and data width is fixed at 9 bits and there are 8 registers.

Ports:
- `Clock`  in  1  system clock, rising edge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `Run`  in  1  start request; sampled only in T0.
- `DIN`  in  9  instruction word. Its immediate operand is driven onto the bus through the mux.
- `Gnz`  in  1  high when `G` is nonzero; used only by `mvnz`.
- `Rout`  out  8  one-hot register-to-bus select. `Rout[7-i]` selects Ri.
- `Gout`  out  1  drives `G` onto the bus.
- `DINout`  out  1  drives `DIN` onto the bus.
- `Rin`  out  8  register load enables, same bit order as `Rout`.
- `Ain`  out  1  load the ALU `A` register from the bus.
- `Gin`  out  1  load `G` with the ALU result.
- `AddSub`  out  1  ALU operation: 0 = add, 1 = subtract.
- `Done`  out  1  one-cycle pulse on the final cycle of an instruction.

## Operation
- The internal register is `IR[8:0]`. Opcode = `IR[8:6]`, X = `IR[5:3]`, Y = `IR[2:0]`.
- FSM states: T0 (idle/fetch), T1, T2, T3.
- **T0**
  - All outputs are 0.
  - If `Run`=1: `IR <= DIN` and go to T1. Otherwise stay in T0.
- **T1**
  - `000 mv Rx,Ry`: assert `Rout`=Y, `Rin`=X, `Done`; go to T0.
  - `001 mvi Rx,#D`: assert `DINout`, `Rin`=X, `Done`; go to T0. The environment holds D on `DIN` during this cycle.
  - `010 add` and `011 sub`: assert `Rout`=X and `Ain`; go to T2.
  - Any other opcode: assert `Done` only, with no writes; go to T0.
- **T2** (add/sub): assert `Rout`=Y and `Gin`. `AddSub` = `IR[6]`. Go to T3.
- **T3** (add/sub): assert `Gout`, `Rin`=X, `Done`; go to T0.
- All outputs are decoded combinationally from the state and `IR` (Moore style, no input dependency except `Gnz`).
- **Bus invariant:** in every cycle, at most one of `Gout`, `DINout`, `Rout[7:0]` is 1. Verification asserts this.
- X = Y is legal. For example, `mv R3,R3` asserts the same bit in `Rout` and `Rin`.
- `Run` is ignored outside T0. A held-high `Run` fetches the next instruction in the cycle after `Done`.

## Timing
- Reset (`Resetn`=0, asynchronous): state = T0 and `IR` = 0 immediately. Every output is 0 while reset is held.
- Reset asserted mid-instruction aborts it. No further `Rin`/`Gin`/`Done` is issued.
- Reset release takes effect on the first rising `Clock`. The FSM sits in T0 until `Run` is sampled high.
- Latency, counting the T0 fetch cycle:
  - mv / mvi / undefined: 2 cycles, with `Done` in cycle 2.
  - add / sub: 4 cycles, with `Done` in cycle 4.
- Register writes and loads occur at the rising edge ending the cycle in which the enable is high.

## Configuration
- **`PROC_MVNZ_EN` defined:** opcode `100 mvnz Rx,Ry` is decoded. In T1:
  - If `Gnz`=1, behave exactly as `mv`.
  - If `Gnz`=0, assert `Done` only, with no `Rout`/`Rin`.
  - Go to T0 in both cases.
- **`PROC_MVNZ_EN` undefined:** opcode `100` is undefined (`Done` only, no writes). The `Gnz` port is still present but is ignored.

## Test plan
- **Reset:** `Resetn`=0 in the middle of an add's T2 → all outputs 0 in the same cycle. After release with `Run`=0, the FSM stays idle and all outputs remain 0.
- **mvi R0,#5:** `Run`=1, `DIN`=9'b001_000_000 → next cycle `DINout`=1, `Rin`=8'b1000_0000, `Done`=1. The following cycle is T0 with all outputs 0.
- **add R1,R2:** `DIN`=9'b010_001_010 →
  - T1: `Rout`=8'b0100_0000, `Ain`=1.
  - T2: `Rout`=8'b0010_0000, `Gin`=1, `AddSub`=0.
  - T3: `Gout`=1, `Rin`=8'b0100_0000, `Done`=1.
- **sub R7,R0 back-to-back with mv R0,R7, `Run` held at 1:** T2 has `AddSub`=1. `IR` reloads in the cycle after T3. The mv then asserts `Rout`=8'b0000_0001 and `Rin`=8'b1000_0000.
- **Opcode 9'b111_000_000:** T1 → `Done`=1, and `Rin`, `Ain`, `Gin` and all bus selects are 0.
- **mvnz R2,R3 with `PROC_MVNZ_EN` defined:**
  - `Gnz`=0 → `Done` only.
  - `Gnz`=1 → `Rout`=8'b0001_0000, `Rin`=8'b0010_0000.
  - With the macro undefined, both cases give `Done` only.
